battle_controller: RTL and testbench
====================================

BATTLE_CONTROLLER -- requirements
Module: battle_controller

Interface
REQ-001 SHALL have parameter ENEMY_HP_MAX, default 192, meaning enemy HP at battle start (11-bit; the menu health bar draws hp>>1 over 96 px).
REQ-002 SHALL have parameter PLAYER_HP_MAX, default 20, meaning player HP at battle start.
REQ-003 SHALL have parameter HIT_DAMAGE, default 2, meaning player HP lost per hit.
REQ-004 SHALL have parameter DODGE_FRAMES, default 300, meaning duration of the dodge phase in video frames.
REQ-005 clk  in  1  system clock; the block has one clock.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 hcount_in  in  11  video horizontal count.
REQ-008 vcount_in  in  10  video vertical count.
REQ-009 menu_finished_in  in  1  one-cycle pulse from the menu when the player commits FIGHT.
REQ-010 attack_finished_in  in  1  one-cycle pulse at the end of the attack-bar phase.
REQ-011 attack_damage_in  in  11  damage to apply; sampled only with attack_finished_in.
REQ-012 player_hit_in  in  1  one-cycle pulse per bullet collision.
REQ-013 restart_in  in  1  level input; a rising edge restarts the battle from WIN or LOSE.
REQ-014 state_out  out  4  game state; this port feeds the menu state_in port.
REQ-015 enemy_hp_left_out  out  11  current enemy HP.
REQ-016 player_hp_out  out  8  current player HP.
REQ-017 turn_count_out  out  8  count of completed turns.
REQ-018 game_over_out  out  1  high while in WIN or LOSE.

Function
REQ-019 state_out encodings SHALL be:
  - INIT 4'b1010
  - MENU 4'b0000
  - ATTACK 4'b0001
  - DODGE 4'b0010
  - WIN 4'b0011
  - LOSE 4'b0100
REQ-020 INIT SHALL last exactly one cycle, then go to MENU, so the downstream menu always sees a change into 4'b0000.
REQ-021 In MENU, menu_finished_in SHALL cause a transition to ATTACK on the next cycle.
REQ-022 In ATTACK, attack_finished_in SHALL update enemy HP as follows:
  - if attack_damage_in >= enemy HP, enemy HP becomes 0 and the next state is WIN;
  - otherwise enemy HP is reduced by attack_damage_in and the next state is DODGE.
REQ-023 A frame tick SHALL be the cycle where hcount_in==0 and vcount_in==0.
REQ-024 On entry to DODGE the frame counter SHALL clear to 0; it SHALL increment on each frame tick.
REQ-025 When the frame counter reaches DODGE_FRAMES-1 and a frame tick occurs, the block SHALL go to MENU and increment turn_count_out, which wraps 255->0.
REQ-026 In DODGE, player_hit_in SHALL reduce player HP by HIT_DAMAGE, saturating at 0; reaching 0 SHALL go to LOSE next cycle.
REQ-027 If a hit and dodge expiry occur in the same cycle, the hit SHALL be applied first; LOSE takes priority over MENU.
REQ-028 Pulses arriving outside their owning state SHALL be ignored, with no HP or state change.
REQ-029 WIN and LOSE SHALL be terminal until a rising edge of restart_in, which goes to INIT and reloads HP to the maximums and turn_count_out to 0.
REQ-030 All outputs SHALL be registered; each state or HP change SHALL be visible on the cycle after the causing pulse.

Reset
REQ-031 Reset SHALL asynchronously set the following:
  - state_out = INIT;
  - enemy_hp_left_out = ENEMY_HP_MAX;
  - player_hp_out = PLAYER_HP_MAX;
  - turn_count_out = 0;
  - game_over_out = 0;
  - frame counter = 0;
  - restart edge register = 0.
REQ-032 Reset asserted mid-DODGE or mid-ATTACK SHALL abandon the phase with no partial HP update.

Structure
REQ-033 A shared package battle_pkg SHALL hold:
  - the state enum, 4-bit, with the encodings of REQ-019;
  - the default HP and damage constants.
REQ-034 Frame-tick detection plus the dodge frame counter SHALL be one sub-module, frame_timer, with clear, tick and done signals.

Verification
REQ-035 Release reset -> state_out is 1010 for one cycle, then 0000; enemy HP 192; player HP 20.
REQ-036 In MENU, pulse menu_finished_in, then in ATTACK pulse attack_finished_in with damage 50 -> enemy HP 142, state DODGE.
REQ-037 DODGE_FRAMES set to 3 for this test; in DODGE, drive 3 frame ticks with no hits -> state MENU, turn_count_out 1.
REQ-038 Player HP 2; in DODGE, pulse player_hit_in on the same cycle as the final frame tick -> player HP 0, state LOSE, game_over_out 1.
REQ-039 Enemy HP 10; pulse attack_finished_in with damage 2047 -> enemy HP 0, state WIN; then raise restart_in -> state INIT, HP reloaded.
REQ-040 Pulse player_hit_in and attack_finished_in while in MENU -> no change; assert rst mid-DODGE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared definitions for the battle controller slice.
//   state_t   : game state, encoded exactly as the menu block decodes state_in
//   *_W       : datapath widths for enemy HP, player HP and the turn counter
//   *_DEF     : default battle tuning constants used as module parameter defaults
package battle_pkg;

  typedef enum logic [3:0] {
    ST_MENU   = 4'b0000,
    ST_ATTACK = 4'b0001,
    ST_DODGE  = 4'b0010,
    ST_WIN    = 4'b0011,
    ST_LOSE   = 4'b0100,
    ST_INIT   = 4'b1010
  } state_t;

  localparam int unsigned ENEMY_HP_W  = 11;
  localparam int unsigned PLAYER_HP_W = 8;
  localparam int unsigned TURN_W      = 8;

  localparam int unsigned ENEMY_HP_MAX_DEF  = 192;
  localparam int unsigned PLAYER_HP_MAX_DEF = 20;
  localparam int unsigned HIT_DAMAGE_DEF    = 2;
  localparam int unsigned DODGE_FRAMES_DEF  = 300;

endpackage

// File: rtl/frame_timer.sv
// Frame-tick detector and dodge-phase frame counter.
//   clk, rst   : system clock, asynchronous active-high reset
//   hcount_in  : video horizontal count
//   vcount_in  : video vertical count
//   clear      : hold the counter at 0 (asserted whenever the battle is not dodging)
//   tick       : combinational, high on the cycle where hcount_in==0 and vcount_in==0
//   done       : counter has reached DODGE_FRAMES-1; the next tick ends the dodge
module frame_timer #(
  parameter int unsigned DODGE_FRAMES = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        clear,
  output logic        tick,
  output logic        done
);

  // The counter never needs to hold more than DODGE_FRAMES-1.
  localparam int unsigned CNT_W = (DODGE_FRAMES > 1) ? $clog2(DODGE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DODGE_FRAMES - 1);

  logic [CNT_W-1:0] count;

  assign tick = (hcount_in == '0) && (vcount_in == '0);
  assign done = (count == LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/battle_controller.sv
// Top-level battle state machine: menu -> attack -> dodge turns until one side
// runs out of HP, then holds WIN/LOSE until restart_in rises.
//   clk, rst            : system clock, asynchronous active-high reset
//   hcount_in/vcount_in : video counters, used to derive the frame tick
//   menu_finished_in    : pulse, player committed FIGHT (honoured in MENU)
//   attack_finished_in  : pulse, attack bar done; attack_damage_in sampled with it
//   player_hit_in       : pulse per bullet collision (honoured in DODGE)
//   restart_in          : level; a rising edge leaves WIN/LOSE
//   state_out           : registered game state, feeds the menu state_in
//   enemy_hp_left_out   : registered enemy HP
//   player_hp_out       : registered player HP
//   turn_count_out      : registered count of completed dodge phases, wraps
//   game_over_out       : registered, high while in WIN or LOSE
module battle_controller
  import battle_pkg::*;
#(
  parameter int unsigned ENEMY_HP_MAX  = ENEMY_HP_MAX_DEF,
  parameter int unsigned PLAYER_HP_MAX = PLAYER_HP_MAX_DEF,
  parameter int unsigned HIT_DAMAGE    = HIT_DAMAGE_DEF,
  parameter int unsigned DODGE_FRAMES  = DODGE_FRAMES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   menu_finished_in,
  input  logic                   attack_finished_in,
  input  logic [ENEMY_HP_W-1:0]  attack_damage_in,
  input  logic                   player_hit_in,
  input  logic                   restart_in,
  output logic [3:0]             state_out,
  output logic [ENEMY_HP_W-1:0]  enemy_hp_left_out,
  output logic [PLAYER_HP_W-1:0] player_hp_out,
  output logic [TURN_W-1:0]      turn_count_out,
  output logic                   game_over_out
);

  localparam logic [ENEMY_HP_W-1:0]  ENEMY_MAX  = ENEMY_HP_W'(ENEMY_HP_MAX);
  localparam logic [PLAYER_HP_W-1:0] PLAYER_MAX = PLAYER_HP_W'(PLAYER_HP_MAX);
  localparam logic [PLAYER_HP_W-1:0] HIT_DMG    = PLAYER_HP_W'(HIT_DAMAGE);

  state_t                 state, state_n;
  logic [ENEMY_HP_W-1:0]  enemy_hp, enemy_hp_n;
  logic [PLAYER_HP_W-1:0] player_hp, player_hp_n;
  logic [TURN_W-1:0]      turn_count, turn_count_n;
  logic                   game_over;
  logic                   restart_q;
  logic                   restart_rise;
  logic                   frame_tick, frame_done;

  // The counter is held cleared outside DODGE, so it is 0 on every entry.
  frame_timer #(
    .DODGE_FRAMES (DODGE_FRAMES)
  ) u_frame_timer (
    .clk       (clk),
    .rst       (rst),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .clear     (state != ST_DODGE),
    .tick      (frame_tick),
    .done      (frame_done)
  );

  assign restart_rise = restart_in & ~restart_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      enemy_hp   <= ENEMY_MAX;
      player_hp  <= PLAYER_MAX;
      turn_count <= '0;
      game_over  <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      state      <= state_n;
      enemy_hp   <= enemy_hp_n;
      player_hp  <= player_hp_n;
      turn_count <= turn_count_n;
      game_over  <= (state_n == ST_WIN) || (state_n == ST_LOSE);
      restart_q  <= restart_in;
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path through
    // the case leaves a variable unassigned and infers a latch.
    state_n      = state;
    enemy_hp_n   = enemy_hp;
    player_hp_n  = player_hp;
    turn_count_n = turn_count;

    unique case (state)
      ST_INIT: state_n = ST_MENU;

      ST_MENU: if (menu_finished_in) state_n = ST_ATTACK;

      ST_ATTACK: begin
        if (attack_finished_in) begin
          if (attack_damage_in >= enemy_hp) begin
            enemy_hp_n = '0;
            state_n    = ST_WIN;
          end else begin
            enemy_hp_n = enemy_hp - attack_damage_in;
            state_n    = ST_DODGE;
          end
        end
      end

      ST_DODGE: begin
        // Hit is resolved before frame expiry so a fatal hit wins over MENU.
        if (player_hit_in) begin
          if (player_hp <= HIT_DMG) begin
            player_hp_n = '0;
            state_n     = ST_LOSE;
          end else begin
            player_hp_n = player_hp - HIT_DMG;
          end
        end
        if ((state_n != ST_LOSE) && frame_tick && frame_done) begin
          state_n      = ST_MENU;
          turn_count_n = turn_count + 1'b1;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (restart_rise) begin
          state_n      = ST_INIT;
          enemy_hp_n   = ENEMY_MAX;
          player_hp_n  = PLAYER_MAX;
          turn_count_n = '0;
        end
      end

      default: state_n = ST_INIT;
    endcase
  end

  assign state_out         = state;
  assign enemy_hp_left_out = enemy_hp;
  assign player_hp_out     = player_hp;
  assign turn_count_out    = turn_count;
  assign game_over_out     = game_over;

endmodule

// File: tb/tb_battle_controller.sv
// Directed bench for battle_controller with DODGE_FRAMES = 3; all expected
// values are hand-computed constants.
module tb_battle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = 11'd5;
  logic [9:0]  vcount_in = 10'd5;
  logic        menu_finished_in = 1'b0;
  logic        attack_finished_in = 1'b0;
  logic [10:0] attack_damage_in = '0;
  logic        player_hit_in = 1'b0;
  logic        restart_in = 1'b0;
  logic [3:0]  state_out;
  logic [10:0] enemy_hp_left_out;
  logic [7:0]  player_hp_out;
  logic [7:0]  turn_count_out;
  logic        game_over_out;

  localparam logic [3:0] S_INIT = 4'b1010, S_MENU = 4'b0000, S_ATTACK = 4'b0001,
                         S_DODGE = 4'b0010, S_WIN = 4'b0011, S_LOSE = 4'b0100;

  int n_checks = 0;
  int n_fail   = 0;

  battle_controller #(
    .DODGE_FRAMES (3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .hcount_in          (hcount_in),
    .vcount_in          (vcount_in),
    .menu_finished_in   (menu_finished_in),
    .attack_finished_in (attack_finished_in),
    .attack_damage_in   (attack_damage_in),
    .player_hit_in      (player_hit_in),
    .restart_in         (restart_in),
    .state_out          (state_out),
    .enemy_hp_left_out  (enemy_hp_left_out),
    .player_hp_out      (player_hp_out),
    .turn_count_out     (turn_count_out),
    .game_over_out      (game_over_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input int ehp,
                           input int php, input int turn, input logic go);
    check({tag, ".state"},  32'(state_out),         32'(st));
    check({tag, ".enemy"},  32'(enemy_hp_left_out), 32'(ehp));
    check({tag, ".player"}, 32'(player_hp_out),     32'(php));
    check({tag, ".turn"},   32'(turn_count_out),    32'(turn));
    check({tag, ".over"},   32'(game_over_out),     32'(go));
  endtask

  // Inputs change 1 ns after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_menu();
    menu_finished_in = 1'b1;
    step();
    menu_finished_in = 1'b0;
  endtask

  task automatic attack(input int dmg);
    attack_finished_in = 1'b1;
    attack_damage_in   = 11'(dmg);
    step();
    attack_finished_in = 1'b0;
    attack_damage_in   = '0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      player_hit_in = 1'b1;
      step();
      player_hit_in = 1'b0;
    end
  endtask

  task automatic frame_tick(input logic with_hit);
    hcount_in     = '0;
    vcount_in     = '0;
    player_hit_in = with_hit;
    step();
    hcount_in     = 11'd5;
    vcount_in     = 10'd5;
    player_hit_in = 1'b0;
  endtask

  task automatic do_restart();
    restart_in = 1'b1;
    step();
    check_all("restart", S_INIT, 192, 20, 0, 1'b0);
    step();
    check_all("restart_menu", S_MENU, 192, 20, 0, 1'b0);
    restart_in = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    check_all("reset", S_INIT, 192, 20, 0, 1'b0);
    step();
    check_all("init_to_menu", S_MENU, 192, 20, 0, 1'b0);

    // Pulses owned by other states are ignored in MENU.
    player_hit_in = 1'b1; attack_finished_in = 1'b1; attack_damage_in = 11'd100;
    step();
    player_hit_in = 1'b0; attack_finished_in = 1'b0; attack_damage_in = '0;
    check_all("menu_ignore", S_MENU, 192, 20, 0, 1'b0);

    pulse_menu();
    check("to_attack", 32'(state_out), 32'(S_ATTACK));
    hits(1);
    check_all("attack_ignore_hit", S_ATTACK, 192, 20, 0, 1'b0);

    attack(50);
    check_all("attack50", S_DODGE, 142, 20, 0, 1'b0);
    frame_tick(1'b0);
    frame_tick(1'b0);
    check_all("dodge_two_ticks", S_DODGE, 142, 20, 0, 1'b0);
    frame_tick(1'b0);
    check_all("dodge_expire", S_MENU, 142, 20, 1, 1'b0);

    // Second turn: bring enemy to 10 and player to 2.
    pulse_menu();
    attack(132);
    check_all("attack132", S_DODGE, 10, 20, 1, 1'b0);
    hits(9);
    check_all("nine_hits", S_DODGE, 10, 2, 1, 1'b0);
    repeat (3) frame_tick(1'b0);
    check_all("turn2_menu", S_MENU, 10, 2, 2, 1'b0);

    pulse_menu();
    attack(2047);
    check_all("win", S_WIN, 0, 2, 2, 1'b1);
    pulse_menu();
    check_all("win_hold", S_WIN, 0, 2, 2, 1'b1);
    do_restart();

    // Fatal hit on the same cycle as dodge expiry.
    pulse_menu();
    attack(1);
    hits(9);
    check_all("pre_lose", S_DODGE, 191, 2, 0, 1'b0);
    frame_tick(1'b0);
    frame_tick(1'b0);
    frame_tick(1'b1);
    check_all("lose", S_LOSE, 191, 0, 0, 1'b1);
    do_restart();

    // Reset abandons an attack on the very cycle it would resolve.
    pulse_menu();
    attack_finished_in = 1'b1; attack_damage_in = 11'd50; rst = 1'b1;
    step();
    attack_finished_in = 1'b0; attack_damage_in = '0;
    check_all("rst_mid_attack", S_INIT, 192, 20, 0, 1'b0);
    rst = 1'b0;
    step();

    // Reset mid-DODGE takes effect without waiting for a clock edge.
    pulse_menu();
    attack(5);
    hits(1);
    frame_tick(1'b0);
    check_all("dodge_before_rst", S_DODGE, 187, 18, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_all("rst_mid_dodge", S_INIT, 192, 20, 0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_menu", 32'(state_out), 32'(S_MENU));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
